// File: rtl/bp_pkg.sv
// Shared branch-predictor types, counter encodings and the 2-bit saturating
// counter update rule.
package bp_pkg;

    localparam int HIST_W_DEF = 7;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_SNT = 2'd0;  // strongly not-taken
    localparam ctr2_t CTR_WNT = 2'd1;  // weakly not-taken
    localparam ctr2_t CTR_WT  = 2'd2;  // weakly taken
    localparam ctr2_t CTR_ST  = 2'd3;  // strongly taken

    // Step a counter toward the resolved direction, holding at either end.
    function automatic ctr2_t sat_update(ctr2_t cnt, logic taken);
        ctr2_t res;
        res = cnt;
        if (taken) begin
            if (cnt != CTR_ST) begin
                res = cnt + 2'd1;
            end
        end else begin
            if (cnt != CTR_SNT) begin
                res = cnt - 2'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_sat_counter2.sv
// One 2-bit saturating counter with a synchronous reset value and an update
// enable; the pattern-history table is built from one of these per entry.
module bp_sat_counter2
    import bp_pkg::*;
#(
    parameter ctr2_t RST_VAL = CTR_WNT
) (
    input  logic  clk,
    input  logic  srst,
    input  logic  en,
    input  logic  taken,
    output ctr2_t cnt_o
);

    ctr2_t cnt_q;
    ctr2_t cnt_d;

    // Next value: saturating step when enabled, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = sat_update(cnt_q, taken);
        end
    end

    // Counter state; reset wins over any update presented in the same cycle.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/gshare_pht.sv
// Gshare pattern-history table: hashes branch PC with global history, returns
// the counter's MSB as the prediction, trains the indexed counter and flags
// mispredictions one cycle after training.
module gshare_pht
    import bp_pkg::*;
#(
    parameter int    HIST_W  = HIST_W_DEF,
    parameter ctr2_t CNT_RST = CTR_WNT
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              predict_valid,
    input  logic [HIST_W-1:0] predict_pc,
    input  logic [31:0]       predict_history,
    output logic              predict_taken,
    output logic [HIST_W-1:0] predict_index,
    input  logic              train_valid,
    input  logic              train_taken,
    input  logic              train_pred_taken,
    input  logic [HIST_W-1:0] train_index,
    output logic              train_mispredicted
);

    localparam int ENTRIES = 2 ** HIST_W;

    ctr2_t cnt_tbl [ENTRIES];
    logic  mispred_q;
    logic  mispred_d;

    // predict_valid carries no state here and upper history bits never reach
    // the index; folded into a sink so they are visibly intentional.
    logic  unused_inputs;
    assign unused_inputs = ^{predict_valid, predict_history[31:HIST_W]};

    // Index hash: only the low HIST_W history bits participate.
    assign predict_index = predict_pc ^ predict_history[HIST_W-1:0];

    // Prediction reads the registered counter, so a same-cycle train to the
    // same entry is not seen until the following cycle.
    assign predict_taken = cnt_tbl[predict_index][1];

    // One counter per table entry, enabled only when training hits its index.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic hit;
            assign hit = train_valid && (train_index == HIST_W'(gi));

            bp_sat_counter2 #(
                .RST_VAL (CNT_RST)
            ) u_ctr (
                .clk   (clk),
                .srst  (areset),
                .en    (hit),
                .taken (train_taken),
                .cnt_o (cnt_tbl[gi])
            );
        end
    endgenerate

    // Mispredict flag for the train presented this cycle.
    always_comb begin
        mispred_d = train_valid && (train_taken != train_pred_taken);
    end

    // Registered one-cycle mispredict pulse; cleared by reset.
    always_ff @(posedge clk) begin
        if (areset) begin
            mispred_q <= 1'b0;
        end else begin
            mispred_q <= mispred_d;
        end
    end

    assign train_mispredicted = mispred_q;

endmodule

// File: tb/tb_gshare_pht.sv
// Scoreboard bench for gshare_pht: the driver computes expected outputs from
// an integer reference table and queues them; a negedge monitor pops and
// compares against the DUT.
module tb_gshare_pht;

    localparam int HW = 7;
    localparam int N  = 2 ** HW;

    logic          clk = 1'b0;
    logic          areset;
    logic          predict_valid;
    logic [HW-1:0] predict_pc;
    logic [31:0]   predict_history;
    logic          predict_taken;
    logic [HW-1:0] predict_index;
    logic          train_valid;
    logic          train_taken;
    logic          train_pred_taken;
    logic [HW-1:0] train_index;
    logic          train_mispredicted;

    typedef struct {
        logic [HW-1:0] idx;
        logic          tk;
        logic          mis;
    } exp_t;

    exp_t sb_q[$];
    int   model [N];
    logic model_mis;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    gshare_pht dut (
        .clk                (clk),
        .areset             (areset),
        .predict_valid      (predict_valid),
        .predict_pc         (predict_pc),
        .predict_history    (predict_history),
        .predict_taken      (predict_taken),
        .predict_index      (predict_index),
        .train_valid        (train_valid),
        .train_taken        (train_taken),
        .train_pred_taken   (train_pred_taken),
        .train_index        (train_index),
        .train_mispredicted (train_mispredicted)
    );

    task automatic model_reset();
        for (int i = 0; i < N; i++) model[i] = 1;
        model_mis = 1'b0;
    endtask

    // Drive one cycle, queue the expected outputs for it, then advance the
    // reference model across the clock edge.
    task automatic step(input logic rst, input logic pv, input logic [HW-1:0] pc,
                        input logic [31:0] hist, input logic tv, input logic tt,
                        input logic tpt, input logic [HW-1:0] ti);
        exp_t e;
        int   k;
        areset           = rst;
        predict_valid    = pv;
        predict_pc       = pc;
        predict_history  = hist;
        train_valid      = tv;
        train_taken      = tt;
        train_pred_taken = tpt;
        train_index      = ti;
        e.idx = pc ^ hist[HW-1:0];
        e.tk  = (model[int'(e.idx)] >= 2);
        e.mis = model_mis;
        sb_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (tv) begin
            k = int'(ti);
            if (tt) model[k] = (model[k] + 1 > 3) ? 3 : model[k] + 1;
            else    model[k] = (model[k] - 1 < 0) ? 0 : model[k] - 1;
            model_mis = (tt != tpt);
        end else begin
            model_mis = 1'b0;
        end
        #1;
    endtask

    task automatic predict(input logic [HW-1:0] pc, input logic [31:0] hist);
        step(1'b0, 1'b1, pc, hist, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic train(input logic [HW-1:0] ti, input logic tt, input logic tpt);
        step(1'b0, 1'b1, ti, 32'h0, 1'b1, tt, tpt, ti);
    endtask

    // Monitor: one set of comparisons per cycle that has a queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks += 3;
            if (predict_index !== e.idx) begin
                n_fail++;
                $display("FAIL pred_index: got %h expected %h", predict_index, e.idx);
            end
            if (predict_taken !== e.tk) begin
                n_fail++;
                $display("FAIL pred_taken idx=%h: got %b expected %b", e.idx, predict_taken, e.tk);
            end
            if (train_mispredicted !== e.mis) begin
                n_fail++;
                $display("FAIL mispredict: got %b expected %b", train_mispredicted, e.mis);
            end
            $display("txn idx=%h taken=%b mis=%b", predict_index, predict_taken, train_mispredicted);
        end
    end

    initial begin
        logic [HW-1:0] tgt;
        logic [31:0]   h;
        int            waited;

        areset = 1'b1; predict_valid = 1'b0; predict_pc = '0; predict_history = '0;
        train_valid = 1'b0; train_taken = 1'b0; train_pred_taken = 1'b0; train_index = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Basic hash after reset
        predict(7'h05, 32'h0000_000A);

        // Every entry predicts not-taken after reset
        for (int i = 0; i < N; i++) predict(HW'(i), 32'h0);

        // Two taken trains on 0x0F, first mispredicted
        train(7'h0F, 1'b1, 1'b0);
        train(7'h0F, 1'b1, 1'b1);
        predict(7'h05, 32'h0000_000A);
        predict(7'h0F, 32'h0);

        // Saturate high then one not-taken
        for (int i = 0; i < 5; i++) train(7'h0F, 1'b1, 1'b1);
        train(7'h0F, 1'b0, 1'b1);
        predict(7'h0F, 32'h0);

        // Same-cycle predict/train on 0x22: old value, then new value
        step(1'b0, 1'b1, 7'h22, 32'h0, 1'b1, 1'b1, 1'b0, 7'h22);
        predict(7'h22, 32'h0);

        // Underflow guard on 0x00
        for (int i = 0; i < 3; i++) train(7'h00, 1'b0, 1'b1);
        predict(7'h00, 32'h0);
        train(7'h00, 1'b1, 1'b0);
        predict(7'h00, 32'h0);

        // Reset overrides a same-cycle train and suppresses the pulse
        train(7'h10, 1'b1, 1'b0);
        train(7'h10, 1'b1, 1'b0);
        step(1'b1, 1'b1, 7'h10, 32'h0, 1'b1, 1'b1, 1'b0, 7'h10);
        predict(7'h10, 32'h0);
        predict(7'h0F, 32'h0);

        // Upper history bits ignored
        predict(7'h00, 32'hFFFF_FF80);
        predict(7'h00, 32'h0000_0000);
        predict(7'h13, 32'hABCD_EF00);

        // Randomised traffic concentrated on a few entries to force collisions
        for (int i = 0; i < 600; i++) begin
            h   = $urandom;
            tgt = HW'($urandom_range(0, 7));
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                 tgt ^ h[HW-1:0], h,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, HW'($urandom_range(0, 7)));
        end

        // Drain the scoreboard with a bounded wait
        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Pattern-history-table stage of the branch predictor.
- Sits directly downstream of the global history shift register. It consumes that register's 32-bit predict_history, hashes it with the branch PC, and returns predict_taken from a table of 2-bit saturating counters.
- On training, it updates the indexed counter and produces a registered mispredict pulse, which is fed back to the history stage for recovery.

Parameters:
- HIST_W, 7, number of history/PC bits used for the index; the table holds 2**HIST_W entries.
- CNT_RST, 2'b01, reset value of every counter (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- areset  in  1  reset; synchronous, active-high.
- predict_valid  in  1  prediction request this cycle.
- predict_pc  in  HIST_W  low PC bits of the branch being predicted.
- predict_history  in  32  global history from the history stage; only bits [HIST_W-1:0] are used.
- predict_taken  out  1  prediction result.
- predict_index  out  HIST_W  index used for this prediction; the core carries it to training.
- train_valid  in  1  training update this cycle.
- train_taken  in  1  resolved branch direction.
- train_pred_taken  in  1  direction that was predicted for this branch.
- train_index  in  HIST_W  index captured at prediction time.
- train_mispredicted  out  1  registered pulse: train_valid & (train_taken != train_pred_taken).

Behaviour:
- Index hash: predict_index = predict_pc ^ predict_history[HIST_W-1:0]; combinational.
- predict_taken = pht[predict_index][1]; combinational, zero latency.
  - predict_taken is driven regardless of predict_valid.
  - predict_valid has no state effect in this block.
- Training, at posedge when train_valid=1:
  - train_taken=1: pht[train_index] increments, saturating at 2'b11.
  - train_taken=0: pht[train_index] decrements, saturating at 2'b00.
- Counter update ignores train_pred_taken; only train_taken drives the update.
- train_mispredicted:
  - Registered one cycle after a train_valid cycle.
  - High for exactly one cycle per mispredicting train.
  - Low whenever the previous cycle had train_valid=0.
- Same-cycle read/write to the same index: the prediction returns the pre-update counter. The update is visible from the next cycle. There is no bypass.
- Consecutive trains to the same index on back-to-back cycles each apply in turn; no update is lost.
- Reset (areset=1 at posedge):
  - All counters become CNT_RST.
  - train_mispredicted becomes 0.
  - A train_valid presented in the reset cycle is discarded.
- Reset asserted mid-operation overrides any pending update in that cycle.
- After reset, predict_taken=0 for every index until training occurs.
- Wrap-around: the index is exactly HIST_W bits. Upper history bits never affect the index.
- X-free requirement: all outputs are defined from the first cycle after reset.

Decomposition:
- Shared package bp_pkg holds:
  - HIST_W default;
  - 2-bit counter typedef ctr2_t;
  - constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3;
  - function sat_update(ctr2_t, logic taken) returning ctr2_t.
- One natural sub-module, bp_sat_counter2: a single 2-bit saturating counter with reset value and enable. The table instantiates it per entry in a generate loop; the alternative is an array plus sat_update, and either is acceptable.

Test Plan:
- Reset, then predict with pc=0x05 and history=0x0A -> predict_index=0x0F, predict_taken=0; train_mispredicted=0.
- Train index 0x0F taken twice (train_pred_taken=0, then 1) -> after the 1st update predict_taken=1 (counter=2); train_mispredicted pulses only one cycle after the first train.
- Train index 0x0F taken 5 more times, then not-taken once -> counter saturates at 3 and ends at 2; predict_taken stays 1.
- Same cycle: predict at index 0x22 and train index 0x22 taken from reset state -> predict_taken=0 that cycle, 1 the next cycle.
- Back-to-back not-taken trains on index 0x00 from reset (3 cycles) -> counter saturates at 0 with no underflow; predict_taken=0.
- Train index 0x10 taken twice, then assert areset in the same cycle as a train to 0x10 -> counter=1 afterwards, predict_taken=0, no train_mispredicted pulse.
- History bits above HIST_W differ (0xFFFFFF80 vs 0x00000000) with pc=0 -> same predict_index=0x00.
